// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator: accumulator sizing, ratio select width
// and the clamp applied to the requested decimation ratio.
package cic_pkg;

  localparam int unsigned OS_SEL_W = 3;

  function automatic int cic_aw(input int dw, input int order, input int max_log2r);
    return dw + order * max_log2r;
  endfunction

  function automatic logic [OS_SEL_W-1:0] clamp_os_sel(input logic [OS_SEL_W-1:0] os,
                                                        input int unsigned max_log2r);
    if (32'(os) > max_log2r) return OS_SEL_W'(max_log2r);
    return os;
  endfunction

  localparam int CIC_AW_DEFAULT = cic_aw(16, 3, 6);
  typedef logic signed [CIC_AW_DEFAULT-1:0] cic_acc_t;

endpackage

// File: rtl/cic_comb_stage.sv
// One comb differencer (M=1): y = x - x_delayed, modulo 2^AW, with its own valid bit.
module cic_comb_stage #(
  parameter int AW = 34
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [AW-1:0] x_i,
  output logic          valid_o,
  output logic [AW-1:0] y_o
);

  logic [AW-1:0] dly_q;
  logic [AW-1:0] y_q;
  logic          valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dly_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      dly_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        y_q   <= x_i - dly_q;
        dly_q <= x_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign y_o     = y_q;

endmodule

// File: rtl/cic_decimator.sv
// Single-clock CIC decimator: ORDER integrators at input rate, runtime ratio 2^os_sel,
// ORDER pipelined combs, gain-normalised round-half-up and saturating output.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int DW        = 16,
  parameter int ORDER     = 3,
  parameter int MAX_LOG2R = 6,
  parameter int AW        = cic_aw(DW, ORDER, MAX_LOG2R)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OS_SEL_W-1:0] os_sel,
  input  logic                in_valid,
  input  logic [DW-1:0]       data_in,
  output logic                out_valid,
  output logic [DW-1:0]       data_out
);

  localparam int unsigned FCW = $clog2(ORDER + 1);
  localparam logic signed [AW:0] SAT_HI = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW:0] SAT_LO = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [AW:0] ONE    = (AW+1)'(1);

  logic [OS_SEL_W-1:0]  os_held_q;
  logic [OS_SEL_W-1:0]  os_eff;
  logic                 flush;
  logic [AW-1:0]        integ_q [ORDER];
  logic [AW-1:0]        integ_d [ORDER];
  logic [MAX_LOG2R-1:0] cnt_q, cnt_d, cnt_max;
  logic                 strobe_q, strobe_d;
  logic [FCW-1:0]       fcnt_q;
  logic                 out_valid_q;
  logic [DW-1:0]        data_out_q;
  logic [ORDER:0][AW-1:0] comb_x;
  logic [ORDER:0]       comb_v;
  logic [7:0]           shift;
  logic signed [AW:0]   ext, bias, rnd, shd;
  logic [DW-1:0]        sat;

  always_comb begin
    os_eff   = clamp_os_sel(os_held_q, MAX_LOG2R);
    flush    = (os_sel != os_held_q);
    cnt_max  = ~({MAX_LOG2R{1'b1}} << os_eff);
    integ_d  = integ_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    if (in_valid) begin
      // Each stage adds the previous stage's old value: a pipelined integrator chain.
      integ_d[0] = integ_q[0] + AW'($signed(data_in));
      for (int unsigned k = 1; k < ORDER; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
      strobe_d = (cnt_q == cnt_max);
      cnt_d    = strobe_d ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      integ_q   <= '{default: '0};
      cnt_q     <= '0;
      strobe_q  <= 1'b0;
      os_held_q <= '0;
    end else if (flush) begin
      integ_q   <= '{default: '0};
      cnt_q     <= '0;
      strobe_q  <= 1'b0;
      os_held_q <= os_sel;
    end else begin
      integ_q   <= integ_d;
      cnt_q     <= cnt_d;
      strobe_q  <= strobe_d;
    end
  end

  assign comb_x[0] = integ_q[ORDER-1];
  assign comb_v[0] = strobe_q;

  for (genvar j = 0; j < ORDER; j++) begin : g_comb
    cic_comb_stage #(.AW(AW)) u_comb (
      .clk     (clk),
      .reset_n (reset_n),
      .flush_i (flush),
      .valid_i (comb_v[j]),
      .x_i     (comb_x[j]),
      .valid_o (comb_v[j+1]),
      .y_o     (comb_x[j+1])
    );
  end

  always_comb begin
    shift = 8'(ORDER) * 8'(os_eff);
    ext   = {comb_x[ORDER][AW-1], comb_x[ORDER]};
    bias  = '0;
    if (shift != 8'd0) bias = ONE << (shift - 8'd1);
    rnd = ext + bias;
    shd = rnd >>> shift;
    if (shd > SAT_HI)      sat = {1'b0, {(DW-1){1'b1}}};
    else if (shd < SAT_LO) sat = {1'b1, {(DW-1){1'b0}}};
    else                   sat = shd[DW-1:0];
  end

  // The first ORDER comb results after a flush or reset are transients: computed, not flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      fcnt_q      <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      fcnt_q      <= '0;
    end else if (comb_v[ORDER]) begin
      data_out_q <= sat;
      if (fcnt_q < FCW'(ORDER)) begin
        fcnt_q      <= fcnt_q + 1'b1;
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= 1'b1;
      end
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Randomised scoreboard bench for cic_decimator against an arithmetic CIC reference model.
module tb_cic_decimator;

  localparam int DW    = 16;
  localparam int ORDER = 3;
  localparam int MAXL  = 6;
  localparam int AW    = DW + ORDER * MAXL;
  localparam longint MASK = (longint'(1) << AW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    os_sel = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          out_valid;
  logic [DW-1:0] data_out;

  always #5 clk = ~clk;

  cic_decimator #(.DW(DW), .ORDER(ORDER), .MAX_LOG2R(MAXL)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .os_sel    (os_sel),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .out_valid (out_valid),
    .data_out  (data_out)
  );

  typedef struct { longint val; longint due; } item_t;
  item_t pend_q[$];
  item_t exp_q[$];

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  longint     integ [ORDER];
  longint     cdly  [ORDER];
  int         cnt;
  int         supp;
  logic [2:0] held;

  function automatic int eff_os(input logic [2:0] os);
    return (int'(os) > MAXL) ? MAXL : int'(os);
  endfunction

  // Gain normalisation of a wrapped AW-bit comb value to a DW-bit output.
  function automatic longint to_out(input longint v, input int sh);
    longint s;
    s = v;
    if (s >= (longint'(1) << (AW-1))) s -= (longint'(1) << AW);
    if (sh > 0) s += longint'(1) << (sh-1);
    s = s >>> sh;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < ORDER; k++) begin
      integ[k] = 0;
      cdly[k]  = 0;
    end
    cnt = 0;
    supp = 0;
  endtask

  task automatic model_reset();
    model_clear();
    held = '0;
    pend_q.delete();
    exp_q.delete();
  endtask

  task automatic model_edge();
    item_t it;
    longint x, v, y;
    if (os_sel != held) begin
      pend_q.delete();
      model_clear();
      held = os_sel;
    end else begin
      while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        it = pend_q.pop_front();
        if (supp < ORDER) supp++;
        else exp_q.push_back(it);
      end
      if (in_valid) begin
        x = longint'($signed(data_in)) & MASK;
        for (int k = ORDER-1; k >= 1; k--) integ[k] = (integ[k] + integ[k-1]) & MASK;
        integ[0] = (integ[0] + x) & MASK;
        if (cnt == (1 << eff_os(held)) - 1) begin
          cnt = 0;
          v = integ[ORDER-1];
          for (int j = 0; j < ORDER; j++) begin
            y = (v - cdly[j]) & MASK;
            cdly[j] = v;
            v = y;
          end
          it.val = to_out(v, ORDER * eff_os(held));
          it.due = cyc + ORDER + 1;
          pend_q.push_back(it);
        end else begin
          cnt++;
        end
      end
    end
  endtask

  task automatic step(input logic [2:0] os, input logic v, input logic [DW-1:0] d);
    os_sel   = os;
    in_valid = v;
    data_in  = d;
    @(posedge clk);
    cyc++;
    if (reset_n) model_edge();
    #1;
  endtask

  // mode: 0 DC, 1 ramp, 2 random data; vpat: 0 continuous, 1 alternate, 2 random ~75%
  task automatic run(input int n, input logic [2:0] os, input int mode, input int dc,
                     input int vpat);
    logic v;
    logic [DW-1:0] d;
    int rampv;
    rampv = 0;
    for (int i = 0; i < n; i++) begin
      case (vpat)
        0:       v = 1'b1;
        1:       v = (i % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      case (mode)
        0:       d = DW'(dc);
        1:       d = DW'(rampv);
        default: d = DW'($urandom);
      endcase
      if (mode == 1 && v) rampv++;
      step(os, v, d);
    end
  endtask

  always @(negedge clk) begin
    item_t e;
    if (reset_n && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out cyc=%0d actual=%0d required=no output", cyc,
                 $signed(data_out));
      end else begin
        e = exp_q.pop_front();
        if (longint'($signed(data_out)) != e.val || cyc != e.due) begin
          errors++;
          $display("FAIL out_sample actual=%0d@cyc%0d required=%0d@cyc%0d",
                   $signed(data_out), cyc, e.val, e.due);
        end
      end
    end
  end

  task automatic check_idle(input string name);
    checks++;
    if (out_valid !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL %s actual=out_valid %b data_out %0d required=0/0", name, out_valid,
               $signed(data_out));
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) step(3'd0, 1'b0, '0);
    check_idle("reset_state");
    reset_n = 1'b1;

    run(300, 3'd3, 0, 1000, 0);
    run(12000, 3'd6, 0, 32767, 0);
    run(12000, 3'd6, 0, -32768, 0);
    run(200, 3'd0, 1, 0, 0);
    run(64, 3'd2, 0, 700, 0);
    run(16 * 8, 3'd4, 0, 700, 0);
    run(200, 3'd1, 0, 500, 1);
    for (int s = 0; s < 6; s++)
      run($urandom_range(200, 600), 3'($urandom_range(0, 7)), 2, 0, 2);
    run(60, 3'd0, 1, 0, 0);

    #1 reset_n = 1'b0;
    #1 check_idle("reset_midblock");
    model_reset();
    for (int i = 0; i < 3; i++) step(3'd0, 1'b1, '0);
    reset_n = 1'b1;
    run(100, 3'd0, 2, 0, 0);
    run(300, 3'd2, 0, -1234, 2);
    run(ORDER + 10, 3'd2, 0, 0, 3);
    for (int i = 0; i < ORDER + 10; i++) step(3'd2, 1'b0, '0);

    checks++;
    if (exp_q.size() != 0 || pend_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d outstanding required=0", exp_q.size() + pend_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
